// File: rtl/jk_reg_array.sv
// jk_reg_array: WIDTH-bit JK-cell register bank with load, up/down count, wrap flag and change mask
// Optional JK_SATURATE_EN makes counting saturate at the limits instead of wrapping.
module jk_reg_array #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             tc,
  output logic [WIDTH-1:0] chg
);
  logic [WIDTH-1:0] r_q, r_chg;
  logic             r_tc;
  logic [WIDTH-1:0] w_up, w_dn, w_j, w_k, w_next;
  logic             w_lim, w_hold;
  assign w_up[0] = 1'b1;
  assign w_dn[0] = 1'b1;
  genvar i;
  generate
    for (i = 1; i < WIDTH; i++) begin : g_carry
      assign w_up[i] = w_up[i-1] & r_q[i-1];
      assign w_dn[i] = w_dn[i-1] & ~r_q[i-1];
    end
  endgenerate
  // limit: up from all-ones or down from zero; wraps or saturates depending on build
  assign w_lim = (mode == 2'b10 && &r_q) || (mode == 2'b11 && ~|r_q);
`ifdef JK_SATURATE_EN
  assign w_hold = w_lim;
`else
  assign w_hold = 1'b0;
`endif
  always_comb begin
    w_j = w_hold ? '0 : mode == 2'b00 ? j : mode == 2'b01 ? d : mode == 2'b10 ? w_up : w_dn;
    w_k = w_hold ? '0 : mode == 2'b00 ? k : mode == 2'b01 ? ~d : mode == 2'b10 ? w_up : w_dn;
  end
  assign w_next = (w_j & ~r_q) | (~w_k & r_q);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q   <= RESET_VAL;
      r_tc  <= 1'b0;
      r_chg <= '0;
    end else if (en) begin
      r_q   <= w_next;
      r_tc  <= w_lim;
      r_chg <= r_q ^ w_next;
    end else begin
      r_tc  <= 1'b0;
      r_chg <= '0;
    end
  end
  assign q   = r_q;
  assign qn  = ~r_q;
  assign tc  = r_tc;
  assign chg = r_chg;
endmodule

// File: tb/tb_jk_reg_array.sv
// tb_jk_reg_array: directed and randomized checks of jk_reg_array against an arithmetic reference model
module tb_jk_reg_array;
  localparam int W = 4;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [W-1:0] j = '0, k = '0, d = '0;
  logic [W-1:0] q, qn, chg;
  logic tc;
  int n_chk = 0, n_err = 0;
  int mq = 0, mtc = 0, mchg = 0;
  jk_reg_array #(.WIDTH(W), .RESET_VAL('0)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k), .d(d),
    .q(q), .qn(qn), .tc(tc), .chg(chg)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model();
    int nq;
    bit sat;
`ifdef JK_SATURATE_EN
    sat = 1'b1;
`else
    sat = 1'b0;
`endif
    nq = mq;
    mtc = 0;
    if (en) begin
      case (mode)
        2'd0: for (int b = 0; b < W; b++)
                case ({j[b], k[b]})
                  2'b10: nq = nq | (1 << b);
                  2'b01: nq = nq & ~(1 << b);
                  2'b11: nq = nq ^ (1 << b);
                  default: ;
                endcase
        2'd1: nq = int'(d);
        2'd2: begin mtc = (mq == 15); nq = (mtc && sat) ? mq : (mq + 1) % 16; end
        default: begin mtc = (mq == 0); nq = (mtc && sat) ? mq : (mq + 15) % 16; end
      endcase
    end
    mchg = en ? (mq ^ nq) : 0;
    mq = nq;
  endtask
  task automatic chk_all(input string tag);
    chk({tag, ".q"}, 32'(q), 32'(mq));
    chk({tag, ".qn"}, 32'(qn), 32'((~mq) & 15));
    chk({tag, ".tc"}, 32'(tc), 32'(mtc));
    chk({tag, ".chg"}, 32'(chg), 32'(mchg));
  endtask
  task automatic step(input string tag);
    @(posedge clk);
    model();
    #1;
    chk_all(tag);
  endtask
  task automatic do_rst();
    #2 rst = 1'b1;
    #1;
    mq = 0; mtc = 0; mchg = 0;
    chk_all("async_rst");
    #1 rst = 1'b0;
  endtask
  initial begin
    #2;
    chk_all("reset");
    #10 rst = 1'b0;
    en = 1'b1; mode = 2'd1; d = 4'h5;
    step("t1_load");
    chk("t1_q5", 32'(q), 32'h5);
    do_rst();
    mode = 2'd0; j = 4'b1010; k = 4'b0110;
    step("t2_jk");
    chk("t2_q", 32'(q), 32'hA);
    chk("t2_chg", 32'(chg), 32'hA);
    chk("t2_qn", 32'(qn), 32'h5);
    mode = 2'd1; d = 4'hE;
    step("t3_load");
    mode = 2'd2;
    step("t3_up1");
    chk("t3_qF", 32'(q), 32'hF);
    step("t3_wrap");
`ifndef JK_SATURATE_EN
    chk("t3_q0", 32'(q), 32'h0);
    chk("t3_tc", 32'(tc), 32'h1);
    chk("t3_chg", 32'(chg), 32'hF);
`endif
    mode = 2'd1; d = 4'h0;
    step("t4_load");
    mode = 2'd3;
    step("t4_dn1");
`ifndef JK_SATURATE_EN
    chk("t4_qF", 32'(q), 32'hF);
    chk("t4_tc", 32'(tc), 32'h1);
`endif
    step("t4_dn2");
    mode = 2'd1; d = 4'h3;
    step("t5_load");
    en = 1'b0; mode = 2'd2;
    for (int n = 0; n < 3; n++) begin
      step("t5_hold");
      chk("t5_q3", 32'(q), 32'h3);
      chk("t5_tc0", 32'(tc), 32'h0);
    end
    en = 1'b1; mode = 2'd1; d = 4'hF;
    step("t6_load");
    mode = 2'd2;
    step("t6_e1");
`ifdef JK_SATURATE_EN
    chk("t6_q1", 32'(q), 32'hF); chk("t6_tc1", 32'(tc), 32'h1); chk("t6_chg1", 32'(chg), 32'h0);
`else
    chk("t6_q1", 32'(q), 32'h0); chk("t6_tc1", 32'(tc), 32'h1);
`endif
    step("t6_e2");
`ifdef JK_SATURATE_EN
    chk("t6_q2", 32'(q), 32'hF); chk("t6_tc2", 32'(tc), 32'h1); chk("t6_chg2", 32'(chg), 32'h0);
`else
    chk("t6_q2", 32'(q), 32'h1); chk("t6_tc2", 32'(tc), 32'h0);
`endif
    for (int n = 0; n < 400; n++) begin
      en = ($urandom_range(0, 7) != 0);
      mode = 2'($urandom_range(0, 3));
      j = 4'($urandom); k = 4'($urandom); d = 4'($urandom);
      if (mode == 2'd1 && $urandom_range(0, 1) == 1) d = ($urandom_range(0, 1) == 1) ? 4'hF : 4'h0;
      step("rand");
      if ($urandom_range(0, 49) == 0) do_rst();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
